// File: rtl/rh_bf_pkg.sv
// Shared definitions for the TinyBF serial blocks.
//   uart_rx_state_t            : receiver FSM state encoding
//   UART_DATA_BITS             : data bits per 8N1 frame
//   UART_CLKS_PER_BIT_DEFAULT  : 50 MHz / 115200 baud, shared with the TX side
package rh_bf_pkg;

  localparam int UART_DATA_BITS            = 8;
  localparam int UART_CLKS_PER_BIT_DEFAULT = 434;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_rx_state_t;

endpackage

// File: rtl/rh_bf_sync2.sv
// Generic two-flop synchroniser for asynchronous ui_in pins.
//   clk  : destination clock
//   rst  : asynchronous active-high reset, loads RST_VAL into both flops
//   d_i  : asynchronous input
//   q_o  : synchronised output (2 cycles of latency)
module rh_bf_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/rh_bf_uart_rx.sv
// 8N1 UART receiver feeding the TinyBF core through a valid/ready holding
// register. Flags framing errors and overruns as sticky status bits.
//   clk, rst   : system clock, asynchronous active-high reset
//   ena        : gates detection of new start bits only
//   rx_i       : raw serial line (idle high, asynchronous)
//   rx_data    : held byte, valid while rx_valid
//   rx_valid   : holding register full
//   rx_ready   : consumer takes rx_data in a cycle with rx_valid
//   frame_err  : sticky, stop bit sampled low
//   overrun    : sticky, byte completed while holding register was full
//   err_clr    : clears both sticky flags (a same-cycle event wins)
module rh_bf_uart_rx
  import rh_bf_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int CNT_W        = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic                      rx_i,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      frame_err,
  output logic                      overrun,
  input  logic                      err_clr
);

  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(UART_DATA_BITS - 1);

  logic rxs;

  uart_rx_state_t            state_q,     state_d;
  logic                      rxs_prev_q,  rxs_prev_d;
  logic [CNT_W-1:0]          cnt_q,       cnt_d;
  logic [IDX_W-1:0]          bit_idx_q,   bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q,     shift_d;
  logic [UART_DATA_BITS-1:0] data_q,      data_d;
  logic                      valid_q,     valid_d;
  logic                      frame_err_q, frame_err_d;
  logic                      overrun_q,   overrun_d;

  logic start_fall;
  logic tick_half;
  logic tick_bit;
  logic byte_done;
  logic stop_bad;
  logic overrun_set;

  rh_bf_sync2 #(.RST_VAL(1'b1)) u_sync_rx (
    .clk (clk),
    .rst (rst),
    .d_i (rx_i),
    .q_o (rxs)
  );

  assign start_fall = rxs_prev_q & ~rxs;
  assign tick_half  = (cnt_q == HALF_LAST);
  assign tick_bit   = (cnt_q == BIT_LAST);
  assign byte_done  = (state_q == STOP) && tick_bit && rxs;
  assign stop_bad   = (state_q == STOP) && tick_bit && !rxs;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (ena && start_fall) state_d = START;
      START:     if (tick_half) state_d = rxs ? IDLE : DATA;
      DATA:      if (tick_bit && (bit_idx_q == IDX_LAST)) state_d = STOP;
      STOP:      if (tick_bit) state_d = rxs ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rxs) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_comb begin
    rxs_prev_d  = rxs;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_set = 1'b0;

    case (state_q)
      START: begin
        cnt_d     = tick_half ? '0 : cnt_q + CNT_W'(1);
        bit_idx_d = '0;
      end
      DATA: begin
        if (tick_bit) begin
          cnt_d     = '0;
          shift_d   = {rxs, shift_q[UART_DATA_BITS-1:1]};  // LSB arrives first
          bit_idx_d = bit_idx_q + IDX_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP:    cnt_d = tick_bit ? '0 : cnt_q + CNT_W'(1);
      default: cnt_d = '0;
    endcase

    // A completing byte may replace the held one only if it is being taken
    // in this very cycle; otherwise the new byte is dropped.
    if (byte_done) begin
      if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_set = 1'b1;
      end
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end

    frame_err_d = (frame_err_q & ~err_clr) | stop_bad;
    overrun_d   = (overrun_q & ~err_clr) | overrun_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxs_prev_q  <= 1'b1;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rxs_prev_q  <= rxs_prev_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_rh_bf_uart_rx.sv
// Directed and randomised checks of the UART receiver at CLKS_PER_BIT=8.
module tb_rh_bf_uart_rx;
  import rh_bf_pkg::*;

  localparam int CPB = 8;
  // Posedge (counted from the one just before the start bit is driven) at
  // which the receiver judges the stop bit: 2 synchroniser cycles, 1 edge
  // detect cycle, half a bit in START, then 8 data bits and the stop bit.
  localparam int DONE_OFS = 3 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic       rx_i = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       frame_err;
  logic       overrun;
  logic       err_clr = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] acc_q[$];
  logic [7:0] exp_q[$];
  int         rise_cnt = 0;
  logic       prev_valid = 1'b0;
  logic       track_valid = 1'b0;
  logic       valid_dropped = 1'b0;

  rh_bf_uart_rx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .rx_i      (rx_i),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  // Observe the interface mid-cycle, where inputs and outputs are both settled.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid <= 1'b0;
    end else begin
      if (rx_valid && rx_ready) begin
        acc_q.push_back(rx_data);
        $display("[%0t] accepted byte 0x%02h", $time, rx_data);
      end
      if (rx_valid && !prev_valid) rise_cnt++;
      if (track_valid && !rx_valid) valid_dropped = 1'b1;
      prev_valid <= rx_valid;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_acc(input string tag, input logic [7:0] exp);
    logic [31:0] got;
    got = (acc_q.size() != 0) ? 32'(acc_q.pop_front()) : 32'hFFFF_FFFF;
    check(tag, got, 32'(exp));
  endtask

  task automatic drive_bit(input logic v);
    rx_i = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a posedge; returns 1 time unit after a posedge.
  task automatic send_byte(input logic [7:0] b, input logic stop_val);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_val);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int         r0;
    logic [7:0] b;

    // Reset state
    idle(3);
    check("reset rx_valid", 32'(rx_valid), 0);
    check("reset rx_data", 32'(rx_data), 0);
    check("reset frame_err", 32'(frame_err), 0);
    check("reset overrun", 32'(overrun), 0);
    check("reset state", 32'(dut.state_q), 32'(IDLE));
    rst = 1'b0;
    idle(4);

    // 1: single byte, consumer always ready
    rx_ready = 1'b1;
    r0 = rise_cnt;
    send_byte(8'hA5, 1'b1);
    idle(3);
    expect_acc("t1 byte", 8'hA5);
    check("t1 one pulse", 32'(rise_cnt - r0), 1);
    check("t1 rx_valid low", 32'(rx_valid), 0);
    check("t1 frame_err", 32'(frame_err), 0);
    check("t1 overrun", 32'(overrun), 0);

    // 2: back-to-back bytes with consumer stalled
    rx_ready = 1'b0;
    send_byte(8'h3C, 1'b1);
    send_byte(8'h7E, 1'b1);
    idle(2);
    check("t2 held data", 32'(rx_data), 32'h3C);
    check("t2 rx_valid", 32'(rx_valid), 1);
    check("t2 overrun", 32'(overrun), 1);
    rx_ready = 1'b1;
    idle(1);
    rx_ready = 1'b0;
    idle(2);
    check("t2 valid dropped", 32'(rx_valid), 0);
    expect_acc("t2 byte", 8'h3C);
    check("t2 nothing else", 32'(acc_q.size()), 0);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    check("t2 overrun cleared", 32'(overrun), 0);

    // 3: accept old byte in exactly the cycle the new one completes
    send_byte(8'h22, 1'b1);
    idle(2);
    check("t3 first held", 32'(rx_data), 32'h22);
    track_valid = 1'b1;
    valid_dropped = 1'b0;
    fork
      send_byte(8'h11, 1'b1);
      begin
        repeat (DONE_OFS - 1) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
    join
    check("t3 new data", 32'(rx_data), 32'h11);
    check("t3 rx_valid", 32'(rx_valid), 1);
    check("t3 overrun", 32'(overrun), 0);
    expect_acc("t3 old byte", 8'h22);
    idle(2);
    check("t3 valid never dropped", 32'(valid_dropped), 0);
    track_valid = 1'b0;
    rx_ready = 1'b1;
    idle(2);
    expect_acc("t3 drained", 8'h11);

    // 4: short low glitch is a false start
    r0 = rise_cnt;
    rx_i = 1'b0;
    idle(3);
    rx_i = 1'b1;
    idle(2 * CPB);
    check("t4 state idle", 32'(dut.state_q), 32'(IDLE));
    check("t4 no valid", 32'(rise_cnt - r0), 0);
    check("t4 frame_err", 32'(frame_err), 0);
    check("t4 overrun", 32'(overrun), 0);

    // ena low: no frame is started
    ena = 1'b0;
    send_byte(8'h5A, 1'b1);
    idle(4);
    ena = 1'b1;
    check("ena gated", 32'(rise_cnt - r0), 0);
    check("ena gated state", 32'(dut.state_q), 32'(IDLE));

    // 5: framing error followed by a long break
    r0 = rise_cnt;
    send_byte(8'h55, 1'b0);
    idle(10 * CPB);
    check("t5 frame_err", 32'(frame_err), 1);
    check("t5 wait high", 32'(dut.state_q), 32'(WAIT_HIGH));
    idle(10 * CPB);
    check("t5 no valid", 32'(rise_cnt - r0), 0);
    check("t5 still waiting", 32'(dut.state_q), 32'(WAIT_HIGH));
    rx_i = 1'b1;
    idle(CPB);
    send_byte(8'h0F, 1'b1);
    idle(3);
    expect_acc("t5 next byte", 8'h0F);
    check("t5 frame_err sticky", 32'(frame_err), 1);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    check("t5 frame_err cleared", 32'(frame_err), 0);

    // Randomised stream: every well-formed frame reaches the consumer in order
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom);
      idle($urandom_range(0, 12));
      send_byte(b, 1'b1);
      exp_q.push_back(b);
    end
    idle(4);
    check("rand count", 32'(acc_q.size()), 32'(exp_q.size()));
    while (exp_q.size() != 0) expect_acc("rand byte", exp_q.pop_front());

    // 6: reset in the middle of a frame, with a byte and a flag held
    rx_ready = 1'b0;
    b = 8'($urandom);
    send_byte(b, 1'b1);
    send_byte(8'hC3, 1'b1);
    idle(2);
    check("t6 held before reset", 32'(rx_data), 32'(b));
    check("t6 overrun before reset", 32'(overrun), 1);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'hF0 >> i));
    #3 rst = 1'b1;
    #1;
    check("t6 rst rx_valid", 32'(rx_valid), 0);
    check("t6 rst rx_data", 32'(rx_data), 0);
    check("t6 rst overrun", 32'(overrun), 0);
    check("t6 rst frame_err", 32'(frame_err), 0);
    rx_i = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(3);
    rx_ready = 1'b1;
    send_byte(8'h81, 1'b1);
    idle(3);
    expect_acc("t6 byte after reset", 8'h81);
    check("t6 no extra bytes", 32'(acc_q.size()), 0);
    check("t6 frame_err", 32'(frame_err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
